dna_word_assembler: RTL and testbench



---
 rtl/dna_pkg.sv | 18 +
 rtl/dna_word_assembler.sv | 63 ++++++
 tb/tb_dna_word_assembler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dna_pkg.sv
// dna_pkg: shared nucleotide types and constants for the packing and checksum stages
package dna_pkg;

    typedef logic [1:0] base_t;

    // Code 2'b00 carries weight 4 in the checksum; the others weigh their own value
    localparam base_t BASE_0 = 2'b00;
    localparam base_t BASE_1 = 2'b01;
    localparam base_t BASE_2 = 2'b10;
    localparam base_t BASE_3 = 2'b11;

    typedef enum logic {FILL, HOLD} asm_state_e;

    function automatic logic [2:0] base_weight(input base_t b);
        return (b == BASE_0) ? 3'd4 : {1'b0, b};
    endfunction

endpackage

// File: rtl/dna_word_assembler.sv
// dna_word_assembler: packs N 2-bit bases into one 2N-bit word, flushing short frames with pad digits
module dna_word_assembler
    import dna_pkg::*;
#(
    parameter int    N        = 6,
    parameter base_t PAD_BASE = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  base_t                  in_base,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [2*N-1:0]         word_out,
    output logic [$clog2(N+1)-1:0] word_len,
    output logic                   word_last,
    output logic                   word_valid,
    input  logic                   word_ready
);

    localparam int CW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    asm_state_e    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          close;

    assign in_ready   = (state == FILL);
    assign word_valid = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign close      = accept && (in_last || cnt == CW'(N - 1));

    // Digit capture, pad fill on the closing base, and FILL/HOLD sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            word_out  <= '0;
            word_len  <= '0;
            word_last <= 1'b0;
        end else if (state == FILL) begin
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    if (CW'(k) == cnt)
                        word_out[2*k +: 2] <= in_base;
                    else if (close && CW'(k) > cnt)
                        word_out[2*k +: 2] <= PAD_BASE;
                end
                cnt <= cnt + 1'b1;
                if (close) begin
                    state     <= HOLD;
                    word_len  <= LW'(cnt) + LW'(1);
                    word_last <= in_last;
                end
            end
        end else if (word_ready) begin
            state <= FILL;
            cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_dna_word_assembler.sv
// tb_dna_word_assembler: directed and random stimulus checked against a queue-based packing model
module tb_dna_word_assembler;
    import dna_pkg::*;

    localparam int    N   = 6;
    localparam base_t PAD = 2'b01;

    logic         clk = 1'b0;
    logic         rst;
    base_t        in_base;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [2*N-1:0] word_out;
    logic [2:0]   word_len;
    logic         word_last;
    logic         word_valid;
    logic         word_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: bases collected in a queue; a word is built from it arithmetically
    base_t          q[$];
    bit             m_fill = 1'b1;
    logic [2*N-1:0] exp_word;
    int             exp_len;
    bit             exp_last;

    dna_word_assembler #(.N(N), .PAD_BASE(PAD)) dut (
        .clk(clk), .rst(rst), .in_base(in_base), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .word_out(word_out), .word_len(word_len), .word_last(word_last),
        .word_valid(word_valid), .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_word();
        exp_word = '0;
        for (int k = 0; k < N; k++)
            exp_word += (2*N)'(k < q.size() ? q[k] : PAD) * ((2*N)'(1) << (2 * k));
        exp_len = q.size();
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs after the edge
    task automatic cyc(input bit v, input base_t b, input bit l, input bit r);
        in_valid = v; in_base = b; in_last = l; word_ready = r;
        chk("in_ready", in_ready, m_fill);
        @(posedge clk); #1;
        if (m_fill) begin
            if (v) begin
                q.push_back(b);
                if (q.size() == N || l) begin
                    build_word();
                    exp_last = l;
                    m_fill = 1'b0;
                end
            end
        end else if (r) begin
            m_fill = 1'b1;
            q.delete();
        end
        chk("word_valid", word_valid, !m_fill);
        if (!m_fill) begin
            chk("word_out", word_out, exp_word);
            chk("word_len", word_len, exp_len);
            chk("word_last", word_last, exp_last);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_len", word_len, 0);
        chk("rst_last", word_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_fill = 1'b1;
        q.delete();
        chk("rst_ready", in_ready, 1);
    endtask

    task automatic send_word(input int n, input bit last_on_final, input bit r);
        for (int i = 0; i < n; i++)
            cyc(1'b1, base_t'($urandom_range(0, 3)), last_on_final && i == n - 1, r);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_base = 0; in_last = 0; word_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", word_valid, 0);
        chk("init_word", word_out, 0);
        chk("init_len", word_len, 0);
        chk("init_last", word_last, 0);
        rst = 1'b0;
        chk("init_ready", in_ready, 1);

        // Full word 1,2,3,0,1,2
        cyc(1, 2'd1, 0, 1); cyc(1, 2'd2, 0, 1); cyc(1, 2'd3, 0, 1);
        cyc(1, 2'd0, 0, 1); cyc(1, 2'd1, 0, 1); cyc(1, 2'd2, 0, 1);
        chk("full_word", word_out, 12'h939);
        chk("full_len", word_len, 6);
        chk("full_last", word_last, 0);
        cyc(0, 2'd0, 0, 1);
        chk("full_one_cycle", word_valid, 0);

        // Short frame 3,3 with last
        cyc(1, 2'd3, 0, 1); cyc(1, 2'd3, 1, 1);
        chk("short_word", word_out, 12'h55F);
        chk("short_len", word_len, 2);
        chk("short_last", word_last, 1);
        cyc(0, 2'd0, 0, 1);

        // Backpressure with bases presented while held
        send_word(N, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, base_t'($urandom_range(0, 3)), 0, 0);
        cyc(1, 2'd2, 0, 1);
        send_word(N, 0, 1);
        cyc(0, 2'd0, 0, 1);

        // Back-to-back streaming
        for (int i = 0; i < 14; i++) cyc(1, base_t'($urandom_range(0, 3)), 0, 1);
        cyc(0, 2'd0, 0, 1);

        // Reset mid-FILL then a clean word
        send_word(3, 0, 0);
        do_reset();
        send_word(N, 0, 0);
        cyc(0, 2'd0, 0, 1);

        // Reset mid-HOLD then a clean word
        send_word(N, 0, 0);
        do_reset();
        send_word(N, 0, 0);
        chk("post_rst_len", word_len, 6);
        cyc(0, 2'd0, 0, 1);

        // Last on the N-th base
        send_word(N, 1, 1);
        chk("lastN_len", word_len, 6);
        chk("lastN_last", word_last, 1);
        cyc(0, 2'd0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, base_t'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
